ahb_slave_mem: RTL and testbench

//  Parametrised AHB-Lite memory slave: next generation of the team's AHB slave. Single-port

---
 rtl/ahb_slave_mem_if.sv | 32 +++
 rtl/ahb_slave_mem.sv | 159 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle for one slave (HSEL from the decoder, HREADY from the response mux).
// The slave modport is used by ahb_slave_mem; the master modport is used by the driving side.
interface ahb_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR_i;
  logic              HWRITE_i;
  logic [2:0]        HSIZE_i;
  logic [2:0]        HBURST_i;
  logic [3:0]        HPROT_i;
  logic [1:0]        HTRANS_i;
  logic              HMASTLOCK_i;
  logic              HREADY_i;
  logic [DATA_W-1:0] HWDATA_i;
  logic              HREADYOUT_o;
  logic              HRESP_o;
  logic [DATA_W-1:0] HRDATA_o;

  modport slave (
    input  HSEL, HADDR_i, HWRITE_i, HSIZE_i, HBURST_i, HPROT_i, HTRANS_i,
           HMASTLOCK_i, HREADY_i, HWDATA_i,
    output HREADYOUT_o, HRESP_o, HRDATA_o
  );

  modport master (
    output HSEL, HADDR_i, HWRITE_i, HSIZE_i, HBURST_i, HPROT_i, HTRANS_i,
           HMASTLOCK_i, HREADY_i, HWDATA_i,
    input  HREADYOUT_o, HRESP_o, HRDATA_o
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory slave: byte/half/word(/dword) writes, two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to build the WAIT state and honour WAIT_STATES.
module ahb_slave_mem #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input logic           HCLK_i,
  input logic           HRESETn_i,
  ahb_slave_mem_if.slave bus
);

  localparam int NB      = DATA_W / 8;
  localparam int BYTE_LG = $clog2(NB);
  localparam int IDX_W   = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef AHB_SLV_WAIT_EN
    S_WAIT = 3'd4,
`endif
    S_XFER = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BYTE_LG-1:0] off_q, off_d;
  logic [2:0]         size_q, size_d;
  logic               write_q, write_d;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]         cnt_q, cnt_d;
`endif

  logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  word_addr;
  logic               addr_bad;
  logic               can_accept;
  logic               accept;
  logic               ready;
  logic               resp;
  logic [NB-1:0]      lane_en;

  // Address-phase decode: errors are resolved here so a bad beat never reaches XFER.
  always_comb begin
    offset    = bus.HADDR_i - BASE_ADDR;
    word_addr = offset >> BYTE_LG;
    addr_bad  = (bus.HADDR_i < BASE_ADDR)
              || (word_addr >= ADDR_W'(MEM_DEPTH))
              || (bus.HSIZE_i > 3'(BYTE_LG))
              || (|(offset[2:0] & ((3'd1 << bus.HSIZE_i) - 3'd1)));
  end

  assign can_accept = (state_q == S_IDLE) || (state_q == S_XFER) || (state_q == S_ERR2);
  assign accept     = bus.HSEL && bus.HREADY_i && bus.HTRANS_i[1] && can_accept;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    ready   = 1'b1;
    resp    = 1'b0;
`ifdef AHB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
`ifdef AHB_SLV_WAIT_EN
      S_WAIT: begin
        ready = 1'b0;
        if (cnt_q == 4'(WAIT_STATES - 1)) state_d = S_XFER;
        else                              cnt_d   = cnt_q + 4'd1;
      end
`endif
      S_ERR1: begin
        ready   = 1'b0;
        resp    = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2:  resp = 1'b1;
      default: ;
    endcase

    if (can_accept) begin
      state_d = S_IDLE;
      if (accept) begin
        idx_d   = word_addr[IDX_W-1:0];
        off_d   = offset[BYTE_LG-1:0];
        size_d  = bus.HSIZE_i;
        write_d = bus.HWRITE_i;
        if (addr_bad) begin
          state_d = S_ERR1;
        end else begin
          state_d = S_XFER;
`ifdef AHB_SLV_WAIT_EN
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
`ifdef AHB_SLV_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Little-endian lane select: lanes [off, off + 2**size) of the word.
  always_comb begin
    lane_en = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q))) lane_en[b] = 1'b1;
    end
  end

  // Storage is not reset; a reset forces state_q out of XFER, so a pending write is dropped.
  always_ff @(posedge HCLK_i) begin
    if ((state_q == S_XFER) && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_en[b]) mem_q[idx_q][8*b +: 8] <= bus.HWDATA_i[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT_o = ready;
  assign bus.HRESP_o     = resp;
  assign bus.HRDATA_o    = ((state_q == S_XFER) && !write_q) ? mem_q[idx_q] : '0;

  logic unused_ok;
  assign unused_ok = ^{bus.HBURST_i, bus.HPROT_i, bus.HMASTLOCK_i, bus.HTRANS_i[0],
                       4'(WAIT_STATES)};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: the driver queues expected responses per accepted beat,
// the monitor checks wait count, HRESP and HRDATA for each data phase.
module tb_ahb_slave_mem;

  localparam int          MEM_DEPTH = 64;
  localparam logic [31:0] BASE      = 32'h0000_1000;
`ifdef AHB_SLV_WAIT_EN
  localparam int          WEXP      = 3;
`else
  localparam int          WEXP      = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.HREADY_i = bus.HREADYOUT_o;

  ahb_slave_mem #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)
  ) dut (
    .HCLK_i   (clk),
    .HRESETn_i(rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wait_cnt = 0;
  logic [31:0] pend_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one data-phase cycle per negedge; pops when the slave signals ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (q.size() > 0) begin
      if (!bus.HREADYOUT_o) begin
        wait_cnt++;
        chk("resp_low", 32'(bus.HRESP_o), 32'(q[0].err));
        chk("rdata_low", bus.HRDATA_o, 32'h0);
        if (wait_cnt > 40) begin
          chk("wait_budget", 32'(wait_cnt), 32'(q[0].waits));
          void'(q.pop_front());
          wait_cnt = 0;
        end
      end else begin
        chk("resp", 32'(bus.HRESP_o), 32'(q[0].err));
        chk("rdata", bus.HRDATA_o, q[0].rdata);
        chk("waits", 32'(wait_cnt), 32'(q[0].waits));
        void'(q.pop_front());
        wait_cnt = 0;
      end
    end else begin
      chk("idle_ready", 32'(bus.HREADYOUT_o), 32'h1);
      chk("idle_resp", 32'(bus.HRESP_o), 32'h0);
    end
  end

  // Drive one address phase (called #1 after a posedge); HWDATA carries the previous beat's data.
  task automatic ahb(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic err, input logic [31:0] rdata);
    int n;
    exp_t e;
    bus.HSEL     = sel;
    bus.HTRANS_i = trans;
    bus.HWRITE_i = wr;
    bus.HSIZE_i  = sz;
    bus.HADDR_i  = addr;
    bus.HWDATA_i = pend_wdata;
    n = 0;
    @(negedge clk);
    while (!bus.HREADYOUT_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("drv_ready", 32'(bus.HREADYOUT_o), 32'h1);
    @(posedge clk);
    #1;
    if (sel && trans[1]) begin
      e.err   = err;
      e.rdata = rdata;
      e.waits = err ? 1 : WEXP;
      q.push_back(e);
      pend_wdata = wdata;
    end
  endtask

  task automatic idle(input int cycles);
    bus.HTRANS_i = 2'b00;
    bus.HWDATA_i = pend_wdata;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.HSEL        = 1'b0;
    bus.HADDR_i     = '0;
    bus.HWRITE_i    = 1'b0;
    bus.HSIZE_i     = 3'd2;
    bus.HBURST_i    = 3'd0;
    bus.HPROT_i     = 4'd3;
    bus.HTRANS_i    = 2'b00;
    bus.HMASTLOCK_i = 1'b0;
    bus.HWDATA_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.HREADYOUT_o), 32'h1);
    chk("rst_resp", 32'(bus.HRESP_o), 32'h0);
    chk("rst_rdata", bus.HRDATA_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    //   sel   trans  wr    sz    addr           wdata          err   rdata
    ahb(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    ahb(1'b1, 2'b10, 1'b1, 3'd0, BASE + 32'h11, 32'h0000AA00, 1'b0, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0,        1'b0, 32'hDEADAAEF);
    ahb(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h00, 32'h11223344, 1'b0, 32'h0);
    ahb(1'b1, 2'b10, 1'b1, 3'd1, BASE + 32'h03, 32'hFFFFFFFF, 1'b1, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h00, 32'h0,        1'b0, 32'h11223344);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + MEM_DEPTH * 4, 32'h0, 1'b1, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE - 32'h4,  32'h0,        1'b1, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd3, BASE + 32'h08, 32'h0,        1'b1, 32'h0);
    ahb(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h20, 32'h01020304, 1'b0, 32'h0);
    ahb(1'b1, 2'b11, 1'b1, 3'd1, BASE + 32'h22, 32'hCAFE0000, 1'b0, 32'h0);
    ahb(1'b1, 2'b11, 1'b0, 3'd2, BASE + 32'h20, 32'h0,        1'b0, 32'hCAFE0304);
    ahb(1'b1, 2'b10, 1'b1, 3'd0, BASE + 32'h23, 32'h77000000, 1'b0, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h20, 32'h0,        1'b0, 32'h77FE0304);
    ahb(1'b1, 2'b01, 1'b0, 3'd2, BASE + 32'h20, 32'h0,        1'b0, 32'h0);
    ahb(1'b0, 2'b10, 1'b1, 3'd2, BASE + 32'h20, 32'h0,        1'b0, 32'h0);
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h00, 32'h0,        1'b0, 32'h11223344);
    idle(3);

    // Abort an in-flight read with reset; memory must survive.
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0, 1'b0, 32'hDEADAAEF);
`ifdef AHB_SLV_WAIT_EN
    chk("pre_rst_wait", 32'(bus.HREADYOUT_o), 32'h0);
`else
    chk("pre_rst_data", bus.HRDATA_o, 32'hDEADAAEF);
`endif
    rst_n        = 1'b0;
    bus.HTRANS_i = 2'b00;
    #1;
    chk("abort_ready", 32'(bus.HREADYOUT_o), 32'h1);
    chk("abort_resp", 32'(bus.HRESP_o), 32'h0);
    chk("abort_rdata", bus.HRDATA_o, 32'h0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    ahb(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0, 1'b0, 32'hDEADAAEF);
    idle(2);

    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("drain", 32'(q.size()), 32'h0);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
